// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with a 2-entry (main + skid) output buffer.
// Optional performance counters are enabled by defining IMM_EXT_PERF_EN.
module imm_ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHL    = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
`ifdef IMM_EXT_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall
`endif
);

  localparam int EXT_W = DATA_W - IMM_W;

  function automatic logic [DATA_W-1:0] extend(input logic [IMM_W-1:0] f,
                                               input logic [2:0]       mode);
    logic [DATA_W-1:0] sx;
    sx = {{EXT_W{f[IMM_W-1]}}, f};
    case (mode)
      3'b000:  extend = sx;
      3'b001:  extend = {{EXT_W{1'b0}}, f};
      3'b010:  extend = {f, {EXT_W{1'b0}}};
      3'b011:  extend = sx << SHL;
      3'b100:  extend = {{EXT_W{1'b1}}, f};
      default: extend = {DATA_W{1'b0}};
    endcase
  endfunction

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [TAG_W-1:0]  m_tag_q,   m_tag_d;
  logic              m_err_q,   m_err_d;
  logic              k_valid_q, k_valid_d;
  logic [DATA_W-1:0] k_data_q,  k_data_d;
  logic [TAG_W-1:0]  k_tag_q,   k_tag_d;
  logic              k_err_q,   k_err_d;
  logic              rdy_q;

  logic              acc;
  logic              pop;
  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  assign acc      = in_valid & rdy_q;
  assign pop      = m_valid_q & out_ready;
  assign ext_data = extend(in_imm, in_mode);
  assign ext_err  = (in_mode > 3'b100);

  // Next-state of main and skid entries; the skid only fills while main is stalled.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_tag_d   = m_tag_q;
    m_err_d   = m_err_q;
    k_valid_d = k_valid_q;
    k_data_d  = k_data_q;
    k_tag_d   = k_tag_q;
    k_err_d   = k_err_q;
    if (!m_valid_q) begin
      if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = ext_data;
        m_tag_d   = in_tag;
        m_err_d   = ext_err;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (pop) begin
      if (k_valid_q) begin
        m_data_d  = k_data_q;
        m_tag_d   = k_tag_q;
        m_err_d   = k_err_q;
        k_valid_d = 1'b0;
      end else if (acc) begin
        m_data_d  = ext_data;
        m_tag_d   = in_tag;
        m_err_d   = ext_err;
      end else begin
        m_valid_d = 1'b0;
      end
    end else begin
      if (acc) begin
        k_valid_d = 1'b1;
        k_data_d  = ext_data;
        k_tag_d   = in_tag;
        k_err_d   = ext_err;
      end else begin
        k_valid_d = k_valid_q;
      end
    end
  end

  // Buffer state; in_ready is registered as the complement of the next skid valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_W{1'b0}};
      m_tag_q   <= {TAG_W{1'b0}};
      m_err_q   <= 1'b0;
      k_valid_q <= 1'b0;
      k_data_q  <= {DATA_W{1'b0}};
      k_tag_q   <= {TAG_W{1'b0}};
      k_err_q   <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_tag_q   <= m_tag_d;
      m_err_q   <= m_err_d;
      k_valid_q <= k_valid_d;
      k_data_q  <= k_data_d;
      k_tag_q   <= k_tag_d;
      k_err_q   <= k_err_d;
      rdy_q     <= ~k_valid_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_tag   = m_tag_q;
  assign out_err   = m_err_q;

`ifdef IMM_EXT_PERF_EN
  logic [31:0] ops_q;
  logic [31:0] stall_q;

  // Accept and stall counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_q   <= 32'd0;
      stall_q <= 32'd0;
    end else if (perf_clr) begin
      ops_q   <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if (acc) begin
        ops_q <= ops_q + 32'd1;
      end
      if (m_valid_q && !out_ready) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (DATA_W=32, IMM_W=16, SHL=2).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;
`ifdef IMM_EXT_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .SHL(2), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
`ifdef IMM_EXT_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                       input logic [4:0] tag);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  task automatic check_out(input string name, input logic [31:0] data, input logic [4:0] tag,
                           input logic err);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"},  64'(out_data),  64'(data));
    check({name, "_tag"},   64'(out_tag),   64'(tag));
    check({name, "_err"},   64'(out_err),   64'(err));
  endtask

  logic [31:0] exp1 [5];

  initial begin
    exp1[0] = 32'hFFFF8001;
    exp1[1] = 32'h00008001;
    exp1[2] = 32'h80010000;
    exp1[3] = 32'hFFFE0004;
    exp1[4] = 32'hFFFF8001;
    reset = 1'b1;
    out_ready = 1'b1;
`ifdef IMM_EXT_PERF_EN
    perf_clr = 1'b0;
`endif
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    reset = 1'b0;

    // Modes 000..100 back to back, each result one edge after its accept
    for (int m = 0; m < 5; m++) begin
      drive(1'b1, 16'h8001, 3'(m), 5'(m));
      step();
      check_out("t1_mode", exp1[m], 5'(m), 1'b0);
    end
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    check("t1_drain_valid", 64'(out_valid), 64'd0);

    drive(1'b1, 16'h7FFF, 3'b000, 5'd3);
    step();
    check_out("t2_sign", 32'h00007FFF, 5'd3, 1'b0);
    drive(1'b1, 16'h7FFF, 3'b011, 5'd4);
    step();
    check_out("t2_sshl", 32'h0001FFFC, 5'd4, 1'b0);
    drive(1'b1, 16'h7FFF, 3'b110, 5'd21);
    step();
    check_out("t2_rsvd", 32'h00000000, 5'd21, 1'b1);
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    check("t2_drain_valid", 64'(out_valid), 64'd0);

    // Eight items at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 3'b001, 5'(i));
      step();
      check("t3_in_ready", 64'(in_ready), 64'd1);
      check_out("t3_item", 32'h00001000 + 32'(i), 5'(i), 1'b0);
    end
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    check("t3_drain_valid", 64'(out_valid), 64'd0);

    // Downstream stall: A into M, B into skid, C held off
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'b000, 5'd10);
    step();
    check("t4_ready_after_a", 64'(in_ready), 64'd1);
    check_out("t4_a", 32'h00000001, 5'd10, 1'b0);
    drive(1'b1, 16'hFFFF, 3'b000, 5'd11);
    step();
    check("t4_ready_after_b", 64'(in_ready), 64'd0);
    check_out("t4_a_hold", 32'h00000001, 5'd10, 1'b0);
    drive(1'b1, 16'h1234, 3'b010, 5'd12);
    step();
    check("t4_ready_stalled", 64'(in_ready), 64'd0);
    check_out("t4_a_hold2", 32'h00000001, 5'd10, 1'b0);
    out_ready = 1'b1;
    step();
    check("t4_ready_after_pop", 64'(in_ready), 64'd1);
    check_out("t4_b", 32'hFFFFFFFF, 5'd11, 1'b0);
    step();
    check_out("t4_c", 32'h12340000, 5'd12, 1'b0);
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    check("t4_drain_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'b000, 5'd1);
    step();
    drive(1'b1, 16'h0002, 3'b000, 5'd2);
    step();
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    check("t5_full_ready", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'd0);
    check("t5_async_ready", 64'(in_ready),  64'd1);
    check("t5_async_data",  64'(out_data),  64'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h0004, 3'b000, 5'd9);
    step();
    check_out("t5_post", 32'h00000004, 5'd9, 1'b0);
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    check("t5_drain_valid", 64'(out_valid), 64'd0);

`ifdef IMM_EXT_PERF_EN
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    check("t6_clr_ops",   64'(perf_ops),   64'd0);
    check("t6_clr_stall", 64'(perf_stall), 64'd0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'(i), 3'b001, 5'(i));
      step();
    end
    out_ready = 1'b0;
    drive(1'b1, 16'h0009, 3'b001, 5'd9);
    step();
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    step();
    step();
    step();
    check("t6_ops",   64'(perf_ops),   64'd10);
    check("t6_stall", 64'(perf_stall), 64'd4);
    out_ready = 1'b1;
    step();
    step();
    check("t6_stall_hold", 64'(perf_stall), 64'd4);
    perf_clr = 1'b1;
    drive(1'b1, 16'h0001, 3'b000, 5'd1);
    step();
    perf_clr = 1'b0;
    drive(1'b0, 16'h0000, 3'b000, 5'd0);
    check("t6_clr_vs_acc", 64'(perf_ops), 64'd0);
    step();
    check("t6_after_clr", 64'(perf_ops), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
